// File: rtl/subword_store_unit.sv
// rtl/subword_store_unit.sv - narrows a register value to byte/halfword/word and stores it via read-modify-write
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request strobe, only looked at while idle
//   size              00 byte, 01 halfword, 10 word, 11 reserved
//   addr, wdata       byte address and register value of the store
//   busy              high whenever a request is in flight
//   done              one-cycle completion pulse (also for rejected requests)
//   err               with done: misaligned address or reserved size, memory untouched
//   trunc_ovf         with done: narrowing dropped significant bits of wdata
//   mem_addr          word address of the access
//   mem_rd, mem_wr    memory strobes, held until mem_ready
//   mem_wdata         merged word to write
//   mem_rdata         read data, taken when mem_rd and mem_ready
//   mem_ready         completes the active strobe on the same edge
module subword_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        trunc_ovf,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nx;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] word_q;
  logic        misaligned;
  logic        trunc_raw;
  logic [31:0] merged;

  // Classified on the live request inputs so the rejection is decided at accept time.
  assign misaligned = (size == 2'b11) ||
                      ((size == 2'b01) && addr[0]) ||
                      ((size == 2'b10) && (addr[1:0] != 2'b00));

  // Insert the narrowed value into its little-endian lane of the word just read.
  always_comb begin
    merged = mem_rdata;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00:   trunc_raw = (wdata_q[31:8] != {24{wdata_q[7]}});
      2'b01:   trunc_raw = (wdata_q[31:16] != {16{wdata_q[15]}});
      default: trunc_raw = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (misaligned)          state_nx = DONE;
          else if (size == 2'b10)  state_nx = WRITE;
          else                     state_nx = READ;
        end
      end
      READ: begin
        mem_rd = 1'b1;
        if (mem_ready) state_nx = WRITE;
      end
      WRITE: begin
        mem_wr = 1'b1;
        if (mem_ready) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request capture and the write word; word stores never pass through READ,
  // so their write word is loaded straight from wdata at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      word_q  <= 32'h0;
    end else begin
      if (state == IDLE && start) begin
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
        err_q   <= misaligned;
        if (size == 2'b10) word_q <= wdata;
      end
      if (state == READ && mem_ready) word_q <= merged;
    end
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = word_q;
  assign err       = done & err_q;
  assign trunc_ovf = done & ~err_q & trunc_raw;

endmodule

// File: tb/tb_subword_store_unit.sv
// tb/tb_subword_store_unit.sv - self-checking bench for subword_store_unit
module tb_subword_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, err, trunc_ovf;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_ready;

  subword_store_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .trunc_ovf(trunc_ovf),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory model: the first strobe of a request waits stall_req cycles.
  int stall_req = 0;
  int stall_cnt = 0;
  assign mem_ready = (stall_cnt >= stall_req);
  always @(posedge clk) begin
    if (!(mem_rd || mem_wr)) stall_cnt <= 0;
    else if (stall_cnt < stall_req) stall_cnt <= stall_cnt + 1;
  end

  // Monitor: records observed writes/dones and protocol violations.
  logic [63:0] obs_wr_q[$];
  logic [1:0]  obs_done_q[$];
  int rd_total = 0, wr_total = 0, done_total = 0;
  int overlap_bad = 0, flag_bad = 0, unstable_bad = 0;
  logic        prev_wr = 1'b0;
  logic [31:0] prev_wdata = 32'h0;
  always @(negedge clk) begin
    if (mem_rd) rd_total++;
    if (mem_wr) wr_total++;
    if (mem_rd && mem_wr) overlap_bad++;
    if (!done && (err || trunc_ovf)) flag_bad++;
    if (mem_wr && prev_wr && mem_wdata != prev_wdata) unstable_bad++;
    prev_wr = mem_wr;
    prev_wdata = mem_wdata;
    if (mem_wr && mem_ready) obs_wr_q.push_back({mem_addr, mem_wdata});
    if (done) begin
      done_total++;
      obs_done_q.push_back({err, trunc_ovf});
    end
  end

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    logic        exp_err;
    logic        exp_trunc;
    logic [31:0] exp_wdata;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[11];
  logic [63:0] exp_wr_q[$];
  logic [1:0]  exp_done_q[$];
  int compared = 0;
  int mismatched = 0;
  int n_req = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, input bit extra_start);
    int rd0, wr0, cyc, exp_rd, exp_wr;
    bit seen;
    logic [63:0] ow;
    logic [1:0]  od;
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy), 64'd0);
    size = v.size; addr = v.addr; wdata = v.wdata; mem_rdata = v.rdata; stall_req = v.stall;
    if (!v.exp_err) exp_wr_q.push_back({v.addr & 32'hFFFF_FFFC, v.exp_wdata});
    exp_done_q.push_back({v.exp_err, v.exp_trunc});
    n_req++;
    rd0 = rd_total; wr0 = wr_total;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble request inputs: the DUT must use its registered copy.
    size = 2'($urandom); addr = $urandom; wdata = $urandom;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("busy_c1", 64'(busy), 64'd1);
      if (extra_start && cyc == 2) start = 1'b1;
      if (extra_start && cyc == 3) start = 1'b0;
      if (done) seen = 1;
    end
    start = 1'b0;
    #1;
    chk("done_seen", 64'(seen), 64'd1);
    chk("latency", 64'(cyc), 64'(v.exp_lat));
    exp_rd = (v.exp_err || v.size == 2'b10) ? 0 : 1 + v.stall;
    exp_wr = v.exp_err ? 0 : (v.size == 2'b10 ? 1 + v.stall : 1);
    chk("rd_cycles", 64'(rd_total - rd0), 64'(exp_rd));
    chk("wr_cycles", 64'(wr_total - wr0), 64'(exp_wr));
    if (!v.exp_err) begin
      if (obs_wr_q.size() == 0) chk("wr_present", 64'd0, 64'd1);
      else begin
        ow = obs_wr_q.pop_front();
        chk("wr_addr_data", ow, exp_wr_q.pop_front());
      end
    end
    if (obs_done_q.size() == 0) chk("done_present", 64'd0, 64'd1);
    else begin
      od = obs_done_q.pop_front();
      chk("err_trunc", 64'(od), 64'(exp_done_q.pop_front()));
    end
  endtask

  initial begin
    int d0;
    vecs[0]  = '{2'b00, 32'h1003, 32'hFFFFFF80, 32'h11223344, 0, 1'b0, 1'b0, 32'h80223344, 3};
    vecs[1]  = '{2'b01, 32'h2002, 32'h00018000, 32'hAAAABBBB, 0, 1'b0, 1'b1, 32'h8000BBBB, 3};
    vecs[2]  = '{2'b10, 32'h0040, 32'hDEADBEEF, 32'h00000000, 3, 1'b0, 1'b0, 32'hDEADBEEF, 5};
    vecs[3]  = '{2'b01, 32'h0101, 32'h00001234, 32'h00000000, 0, 1'b1, 1'b0, 32'h0,        1};
    vecs[4]  = '{2'b10, 32'h0102, 32'h12345678, 32'h00000000, 0, 1'b1, 1'b0, 32'h0,        1};
    vecs[5]  = '{2'b11, 32'h0200, 32'hFFFFFFFF, 32'h00000000, 0, 1'b1, 1'b0, 32'h0,        1};
    vecs[6]  = '{2'b00, 32'h1000, 32'h0000007F, 32'hFFFFFFFF, 0, 1'b0, 1'b0, 32'hFFFFFF7F, 3};
    vecs[7]  = '{2'b00, 32'h1001, 32'h00000100, 32'h00000000, 0, 1'b0, 1'b1, 32'h00000000, 3};
    vecs[8]  = '{2'b01, 32'h3000, 32'hFFFF1234, 32'hCAFEF00D, 0, 1'b0, 1'b1, 32'hCAFE1234, 3};
    vecs[9]  = '{2'b00, 32'h0002, 32'h00000055, 32'h12345678, 2, 1'b0, 1'b0, 32'h12555678, 5};
    vecs[10] = '{2'b10, 32'h0008, 32'h7FFFFFFF, 32'h00000000, 0, 1'b0, 1'b0, 32'h7FFFFFFF, 2};

    rst_n = 1'b0; start = 1'b0; size = 2'b00; addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_flags", 64'({err, trunc_ovf}), 64'd0);
    chk("rst_strobes", 64'({mem_rd, mem_wr}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    #5 rst_n = 1'b1;

    // Back-to-back: each request starts in the first IDLE cycle after the previous done.
    for (int i = 0; i < 11; i++) run_req(vecs[i], i == 2);

    // Reset in WRITE while the memory is stalling.
    @(posedge clk); #1;
    size = 2'b10; addr = 32'h80; wdata = 32'h01020304; stall_req = 10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("pre_rst_wr", 64'(mem_wr), 64'd1);
    d0 = done_total;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_wr", 64'(mem_wr), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_addr", 64'(mem_addr), 64'd0);
    repeat (3) @(negedge clk);
    chk("rst_no_done", 64'(done_total), 64'(d0));
    #2 rst_n = 1'b1;
    stall_req = 0;
    run_req(vecs[0], 1'b0);

    repeat (2) @(negedge clk);
    chk("no_overlap", 64'(overlap_bad), 64'd0);
    chk("flags_only_with_done", 64'(flag_bad), 64'd0);
    chk("wdata_stable", 64'(unstable_bad), 64'd0);
    chk("done_count", 64'(done_total), 64'(n_req));
    chk("extra_writes", 64'(obs_wr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
